// File: rtl/particle_stream_loader.sv
// Particle record streamer: host-writable BRAM replayed in index order over valid/ready
// with a programmable inter-record gap. Optional: PARTICLE_CHECKSUM_EN.
module particle_stream_loader #(
  parameter int unsigned DATA_W      = 256,
  parameter int unsigned ADDR_W      = 9,
  parameter int unsigned N_PARTICLES = 300,
  parameter int unsigned GAP_CYCLES  = 16,
  parameter string       INIT_FILE   = "BRAM_INIT.txt"
) (
  input  logic              fast_clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] data_out,
  output logic              data_out_valid,
  input  logic              data_out_ready,
  output logic [ADDR_W-1:0] index,
  output logic              busy,
  output logic              done,
  output logic [31:0]       checksum
);

  localparam int unsigned       DEPTH    = 2 ** ADDR_W;
  localparam int unsigned       GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_PARTICLES - 1);
  localparam logic [GAP_W-1:0]  GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_PRESENT,
    S_GAP,
    S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic [DATA_W-1:0]   r_data;
  logic                r_valid;
  logic [ADDR_W-1:0]   r_index;
  logic [GAP_W-1:0]    r_gap;
  logic                w_idle;
  logic                w_xfer;
  logic                w_last;

  assign w_idle = (r_state == S_IDLE);
  assign w_xfer = r_valid & data_out_ready;
  assign w_last = (r_index == LAST_IDX);

  always_ff @(posedge fast_clk) begin
    if (wr_en && w_idle) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge fast_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (start) w_next = S_FETCH;
      S_FETCH:   w_next = S_PRESENT;
      S_PRESENT: begin
        if (w_xfer) begin
          if (w_last)               w_next = S_DONE;
          else if (GAP_CYCLES == 0) w_next = S_FETCH;
          else                      w_next = S_GAP;
        end
      end
      S_GAP:     if (r_gap == '0) w_next = S_FETCH;
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge fast_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_index <= '0;
      r_gap   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) r_index <= '0;
        end
        S_FETCH: begin
          r_data  <= r_mem[r_index];
          r_valid <= 1'b1;
        end
        S_PRESENT: begin
          if (w_xfer) begin
            r_valid <= 1'b0;
            if (!w_last) begin
              r_index <= r_index + 1'b1;
              r_gap   <= GAP_LOAD;
            end
          end
        end
        S_GAP: begin
          r_gap <= r_gap - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign data_out       = r_data;
  assign data_out_valid = r_valid;
  assign index          = r_index;
  assign busy           = (r_state == S_FETCH) || (r_state == S_PRESENT) || (r_state == S_GAP);
  assign done           = (r_state == S_DONE);

`ifdef PARTICLE_CHECKSUM_EN
  logic [31:0] r_csum;
  logic [31:0] w_lanes;

  always_comb begin
    w_lanes = '0;
    for (int unsigned i = 0; i < DATA_W / 32; i++) begin
      w_lanes = w_lanes ^ r_data[i*32 +: 32];
    end
  end

  always_ff @(posedge fast_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_csum <= '0;
    end else if (w_idle && start) begin
      r_csum <= '0;
    end else if ((r_state == S_PRESENT) && w_xfer) begin
      r_csum <= r_csum ^ w_lanes;
    end
  end

  assign checksum = r_csum;
`else
  assign checksum = 32'h0;
`endif

endmodule

// File: tb/tb_particle_stream_loader.sv
// Directed bench for particle_stream_loader: a 300-record / gap-16 instance and a 1-record /
// gap-0 instance, BRAM loaded through the host write port.
module tb_particle_stream_loader;

  localparam int N   = 300;
  localparam int GAP = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         a_rst_n, a_start, a_wr_en, a_ready, a_valid, a_busy, a_done;
  logic [8:0]   a_wr_addr, a_index;
  logic [255:0] a_wr_data, a_data;
  logic [31:0]  a_csum;

  logic         b_rst_n, b_start, b_wr_en, b_ready, b_valid, b_busy, b_done;
  logic [8:0]   b_wr_addr, b_index;
  logic [255:0] b_wr_data, b_data;
  logic [31:0]  b_csum;

  int n_cmp = 0;
  int n_err = 0;

  particle_stream_loader #(
    .DATA_W(256), .ADDR_W(9), .N_PARTICLES(N), .GAP_CYCLES(GAP), .INIT_FILE("")
  ) u_a (
    .fast_clk(clk), .reset_n(a_rst_n), .start(a_start), .wr_en(a_wr_en),
    .wr_addr(a_wr_addr), .wr_data(a_wr_data), .data_out(a_data),
    .data_out_valid(a_valid), .data_out_ready(a_ready), .index(a_index),
    .busy(a_busy), .done(a_done), .checksum(a_csum)
  );

  particle_stream_loader #(
    .DATA_W(256), .ADDR_W(9), .N_PARTICLES(1), .GAP_CYCLES(0), .INIT_FILE("")
  ) u_b (
    .fast_clk(clk), .reset_n(b_rst_n), .start(b_start), .wr_en(b_wr_en),
    .wr_addr(b_wr_addr), .wr_data(b_wr_data), .data_out(b_data),
    .data_out_valid(b_valid), .data_out_ready(b_ready), .index(b_index),
    .busy(b_busy), .done(b_done), .checksum(b_csum)
  );

  function automatic logic [255:0] f_rec(input int i);
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[k*32 +: 32] = 32'(i * 8 + k) ^ 32'h5A00_0000;
    return r;
  endfunction

  function automatic logic [31:0] f_fold(input logic [255:0] d);
    logic [31:0] x;
    x = '0;
    for (int k = 0; k < 8; k++) x = x ^ d[k*32 +: 32];
    return x;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One full run on instance A; record 0 is expected as exp0, the rest as f_rec(i).
  task automatic stream(input logic [255:0] exp0, input int bp_idx, input int bp_len,
                        input bit wr0, input bit inject);
    int k, c, last_c, bp_cnt, n_done;
    bit seen;
    logic [31:0]  csum;
    logic [255:0] exp;
    k = 0; c = 0; last_c = 0; bp_cnt = 0; n_done = 0; seen = 0; csum = '0;
    a_ready = 1'b1;
    if (wr0) begin
      a_wr_en = 1'b1; a_wr_addr = '0; a_wr_data = exp0;
    end
    a_start = 1'b1;
    tick;
    a_start = 1'b0; a_wr_en = 1'b0;
    chk("busy_after_start", a_busy, 1);
    chk("valid_in_fetch", a_valid, 0);
    while (n_done == 0 && c < 7000) begin
      tick;
      c++;
      if (inject) begin
        if (c == 50) a_start = 1'b1;
        if (c == 51) a_start = 1'b0;
        if (c == 60) begin a_wr_en = 1'b1; a_wr_addr = 9'd5; a_wr_data = '1; end
        if (c == 61) a_wr_en = 1'b0;
      end
      if (a_valid && !seen) begin
        seen = 1;
        chk("first_valid_latency", c, 1);
      end
      if (a_valid && (a_index == bp_idx) && (bp_cnt < bp_len)) begin
        a_ready = 1'b0;
        bp_cnt++;
        chk("bp_hold_data", a_data, f_rec(bp_idx));
        chk("bp_hold_index", a_index, bp_idx);
      end else begin
        a_ready = 1'b1;
      end
      if (a_valid && a_ready) begin
        exp = (k == 0) ? exp0 : f_rec(k);
        chk("xfer_data", a_data, exp);
        chk("xfer_index", a_index, k);
        if (k > 0) chk("period", c - last_c, GAP + 2 + ((k == bp_idx) ? bp_len : 0));
        last_c = c;
        csum = csum ^ f_fold(exp);
        k++;
      end
      if (a_done) begin
        n_done++;
        chk("busy_at_done", a_busy, 0);
        chk("xfer_count", k, N);
`ifdef PARTICLE_CHECKSUM_EN
        chk("checksum", a_csum, csum);
`else
        chk("checksum_off", a_csum, 0);
`endif
      end
    end
    if (n_done == 0) chk("done_timeout", 0, 1);
    repeat (3) begin
      tick;
      chk("done_single_pulse", a_done, 0);
      chk("busy_after_done", a_busy, 0);
      chk("valid_after_done", a_valid, 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] a5_pat, b_pat;
    a5_pat = {32{8'hA5}};
    b_pat  = {8{32'h1234_5678}};
    a_rst_n = 1'b0; a_start = 1'b0; a_wr_en = 1'b0; a_ready = 1'b0;
    a_wr_addr = '0; a_wr_data = '0;
    b_rst_n = 1'b0; b_start = 1'b0; b_wr_en = 1'b0; b_ready = 1'b0;
    b_wr_addr = '0; b_wr_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", a_valid, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_done", a_done, 0);
    chk("rst_index", a_index, 0);
    chk("rst_data", a_data, 0);
    chk("rst_checksum", a_csum, 0);
    chk("b_rst_valid", b_valid, 0);
    a_rst_n = 1'b1;
    b_rst_n = 1'b1;
    tick;

    for (int i = 0; i < N; i++) begin
      a_wr_en = 1'b1; a_wr_addr = 9'(i); a_wr_data = f_rec(i);
      tick;
    end
    a_wr_en = 1'b0;

    // Plain stream, ready always high.
    stream(f_rec(0), -1, 0, 1'b0, 1'b0);
    // Backpressure on record 7 for 5 cycles.
    stream(f_rec(0), 7, 5, 1'b0, 1'b0);
    // Write + start in the same idle cycle; start and write while busy are ignored.
    stream(a5_pat, -1, 0, 1'b1, 1'b1);

    // Asynchronous reset mid-run.
    a_ready = 1'b1;
    a_start = 1'b1;
    tick;
    a_start = 1'b0;
    repeat (40) tick;
    #2 a_rst_n = 1'b0;
    #1;
    chk("midrun_rst_valid", a_valid, 0);
    chk("midrun_rst_busy", a_busy, 0);
    chk("midrun_rst_done", a_done, 0);
    chk("midrun_rst_index", a_index, 0);
    chk("midrun_rst_checksum", a_csum, 0);
    tick;
    a_rst_n = 1'b1;
    tick;
    chk("post_rst_busy", a_busy, 0);
    // BRAM survives reset: record 0 still the A5 pattern, record 5 untouched by the busy write.
    stream(a5_pat, -1, 0, 1'b0, 1'b0);

    // Single-record, zero-gap instance.
    b_wr_en = 1'b1; b_wr_addr = '0; b_wr_data = b_pat;
    tick;
    b_wr_en = 1'b0;
    b_ready = 1'b1;
    b_start = 1'b1;
    tick;
    b_start = 1'b0;
    chk("b_fetch_valid", b_valid, 0);
    chk("b_fetch_busy", b_busy, 1);
    tick;
    chk("b_present_valid", b_valid, 1);
    chk("b_present_data", b_data, b_pat);
    chk("b_present_index", b_index, 0);
    tick;
    chk("b_done_t3", b_done, 1);
    chk("b_done_busy", b_busy, 0);
    chk("b_done_valid", b_valid, 0);
    tick;
    chk("b_done_cleared", b_done, 0);
    chk("b_idle_valid", b_valid, 0);
    chk("b_idle_index", b_index, 0);
`ifndef PARTICLE_CHECKSUM_EN
    chk("b_checksum_off", b_csum, 0);
`else
    chk("b_checksum", b_csum, f_fold(b_pat));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
